// File: rtl/flags_unit.sv
// Flags register at the consumer end of the ALU result/flags interface.
// Holds S/Z/C/V, a small save/restore stack and a registered branch-condition evaluator.
module flags_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_mask,
  input  logic [3:0] f_in,
  output logic [3:0] flags,
  input  logic       push,
  input  logic       pop,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       err,
  input  logic       err_clr,
  input  logic       cond_req,
  input  logic [3:0] cond_mask,
  input  logic [3:0] cond_val,
  output logic       cond_done,
  output logic       cond_taken
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]     flags_q, flags_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           cond_done_q, cond_done_d;
  logic           cond_taken_q, cond_taken_d;
  logic [3:0]     stack_q [DEPTH];

  logic           full, empty;
  logic           push_only, pop_only;
  logic           push_ok, pop_ok;
  logic           err_set;
  logic [SPW-1:0] sp_m1;
  logic [AW-1:0]  wr_idx, rd_idx;
  logic [3:0]     restored;

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign push_ok   = push_only & ~full;
  assign pop_ok    = pop_only & ~empty;
  assign err_set   = (push & pop) | (push_only & full) | (pop_only & empty);

  assign sp_m1    = sp_q - SPW'(1);
  assign wr_idx   = sp_q[AW-1:0];
  assign rd_idx   = sp_m1[AW-1:0];
  assign restored = stack_q[rd_idx];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    flags_d      = flags_q;
    sp_d         = sp_q;
    err_d        = err_q;
    cond_done_d  = cond_req;
    cond_taken_d = cond_taken_q;

    if (push_ok) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop_ok) begin
      sp_d    = sp_m1;
      flags_d = restored;
    end

    // Restored value goes in first; ALU writes then win bit by bit.
    if (wr_en) begin
      flags_d = (flags_d & ~wr_mask) | (f_in & wr_mask);
    end

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    // Evaluated against the flags registered before this edge.
    if (cond_req) begin
      cond_taken_d = &(~cond_mask | ~(flags_q ^ cond_val));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= '0;
      sp_q         <= '0;
      err_q        <= 1'b0;
      cond_done_q  <= 1'b0;
      cond_taken_q <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      sp_q         <= sp_d;
      err_q        <= err_d;
      cond_done_q  <= cond_done_d;
      cond_taken_q <= cond_taken_d;
    end
  end

  // NOTE: the stack storage is deliberately not reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      stack_q[wr_idx] <= flags_q;
    end
  end

  assign flags       = flags_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign err         = err_q;
  assign cond_done   = cond_done_q;
  assign cond_taken  = cond_taken_q;

endmodule

// File: tb/tb_flags_unit.sv
// Self-checking bench for flags_unit: directed steps followed by random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_flags_unit;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_mask;
  logic [3:0] f_in;
  logic [3:0] flags;
  logic       push;
  logic       pop;
  logic       stack_full;
  logic       stack_empty;
  logic       err;
  logic       err_clr;
  logic       cond_req;
  logic [3:0] cond_mask;
  logic [3:0] cond_val;
  logic       cond_done;
  logic       cond_taken;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  logic       m_err;
  logic       m_done;
  logic       m_taken;

  flags_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_mask    (wr_mask),
    .f_in       (f_in),
    .flags      (flags),
    .push       (push),
    .pop        (pop),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .err        (err),
    .err_clr    (err_clr),
    .cond_req   (cond_req),
    .cond_mask  (cond_mask),
    .cond_val   (cond_val),
    .cond_done  (cond_done),
    .cond_taken (cond_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] m, input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (m[i] && (f[i] != v[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [3:0] nf;
    logic       e;
    if (rst) begin
      m_flags = 4'b0000;
      m_stk.delete();
      m_err   = 1'b0;
      m_done  = 1'b0;
      m_taken = 1'b0;
      return;
    end
    nf = m_flags;
    e  = 1'b0;
    m_done = cond_req;
    if (cond_req) m_taken = cond_eval(m_flags, cond_mask, cond_val);
    if (push && pop) begin
      e = 1'b1;
    end else if (push) begin
      if (m_stk.size() == DEPTH) e = 1'b1;
      else m_stk.push_back(m_flags);
    end else if (pop) begin
      if (m_stk.size() == 0) e = 1'b1;
      else nf = m_stk.pop_back();
    end
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) nf[i] = f_in[i];
      end
    end
    m_flags = nf;
    if (e) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    rst       = 1'b0;
    wr_en     = 1'b0;
    wr_mask   = 4'b0000;
    f_in      = 4'b0000;
    push      = 1'b0;
    pop       = 1'b0;
    err_clr   = 1'b0;
    cond_req  = 1'b0;
    cond_mask = 4'b0000;
    cond_val  = 4'b0000;
  endtask

  // Apply current inputs for one edge, then compare every output with the model.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".flags"}, flags, m_flags);
    check({tag, ".full"},  {3'b000, stack_full},  {3'b000, m_stk.size() == DEPTH});
    check({tag, ".empty"}, {3'b000, stack_empty}, {3'b000, m_stk.size() == 0});
    check({tag, ".err"},   {3'b000, err},        {3'b000, m_err});
    check({tag, ".done"},  {3'b000, cond_done},  {3'b000, m_done});
    check({tag, ".taken"}, {3'b000, cond_taken}, {3'b000, m_taken});
    idle_inputs();
  endtask

  task automatic write_flags(input logic [3:0] v, input string tag);
    wr_en = 1'b1; wr_mask = 4'b1111; f_in = v;
    tick(tag);
  endtask

  initial begin
    idle_inputs();
    m_flags = 4'b0000; m_err = 1'b0; m_done = 1'b0; m_taken = 1'b0;

    // Reset state
    rst = 1'b1; tick("reset");
    check("reset_flags", flags, 4'b0000);
    check("reset_empty", {3'b000, stack_empty}, 4'b0001);
    check("reset_err",   {3'b000, err}, 4'b0000);

    // Masked write: only C
    wr_en = 1'b1; wr_mask = 4'b0010; f_in = 4'b1111; tick("wr_c");
    check("wr_c_only", flags, 4'b0010);

    // Push / pop ordering
    write_flags(4'b1010, "set_a");
    push = 1'b1; tick("push_a");
    write_flags(4'b0101, "set_b");
    push = 1'b1; tick("push_b");
    pop = 1'b1; tick("pop_b");
    check("pop_b_val", flags, 4'b0101);
    pop = 1'b1; tick("pop_a");
    check("pop_a_val", flags, 4'b1010);
    check("pop_a_empty", {3'b000, stack_empty}, 4'b0001);

    // Overflow
    for (int i = 0; i < DEPTH; i++) begin
      push = 1'b1; tick("fill");
    end
    check("full_after_4", {3'b000, stack_full}, 4'b0001);
    check("no_err_yet",   {3'b000, err}, 4'b0000);
    push = 1'b1; tick("overflow");
    check("overflow_err",  {3'b000, err}, 4'b0001);
    check("overflow_full", {3'b000, stack_full}, 4'b0001);
    err_clr = 1'b1; tick("err_clr");
    check("err_cleared", {3'b000, err}, 4'b0000);

    // Underflow
    for (int i = 0; i < DEPTH; i++) begin
      pop = 1'b1; tick("drain");
    end
    pop = 1'b1; tick("underflow");
    check("underflow_err",   {3'b000, err}, 4'b0001);
    check("underflow_flags", flags, 4'b1010);

    // Set and clear in the same cycle: set wins
    push = 1'b1; pop = 1'b1; err_clr = 1'b1; tick("both_err");
    check("set_wins", {3'b000, err}, 4'b0001);
    err_clr = 1'b1; tick("clr2");

    // Conditions
    write_flags(4'b0100, "set_z");
    cond_req = 1'b1; cond_mask = 4'b0100; cond_val = 4'b0100; tick("cond_z1");
    check("cond_z1_done",  {3'b000, cond_done},  4'b0001);
    check("cond_z1_taken", {3'b000, cond_taken}, 4'b0001);
    cond_req = 1'b1; cond_mask = 4'b0100; cond_val = 4'b0000; tick("cond_z0");
    check("cond_z0_done",  {3'b000, cond_done},  4'b0001);
    check("cond_z0_taken", {3'b000, cond_taken}, 4'b0000);
    cond_req = 1'b1; cond_mask = 4'b0000; cond_val = 4'b1011; tick("cond_any");
    check("cond_any_taken", {3'b000, cond_taken}, 4'b0001);
    tick("cond_idle");
    check("cond_idle_done",  {3'b000, cond_done},  4'b0000);
    check("cond_idle_taken", {3'b000, cond_taken}, 4'b0001);

    // Pop with a concurrent ALU write
    write_flags(4'b1111, "set_f");
    push = 1'b1; tick("push_f");
    write_flags(4'b0000, "set_0");
    pop = 1'b1; wr_en = 1'b1; wr_mask = 4'b1000; f_in = 4'b0000; tick("pop_wr");
    check("pop_wr_flags", flags, 4'b0111);

    // Condition sees pre-write flags
    write_flags(4'b0000, "clr_f");
    cond_req = 1'b1; cond_mask = 4'b0100; cond_val = 4'b0100;
    wr_en = 1'b1; wr_mask = 4'b0100; f_in = 4'b0100; tick("cond_prewr");
    check("cond_prewr_taken", {3'b000, cond_taken}, 4'b0000);
    check("cond_prewr_flags", flags, 4'b0100);

    // Reset together with a request
    push = 1'b1; tick("push_pre_rst");
    rst = 1'b1; cond_req = 1'b1; cond_mask = 4'b0000; push = 1'b1; tick("rst_req");
    check("rst_req_done",  {3'b000, cond_done},   4'b0000);
    check("rst_req_flags", flags, 4'b0000);
    check("rst_req_empty", {3'b000, stack_empty}, 4'b0001);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      wr_en     = $urandom_range(0, 1);
      wr_mask   = 4'($urandom);
      f_in      = 4'($urandom);
      push      = ($urandom_range(0, 3) == 0);
      pop       = ($urandom_range(0, 3) == 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      cond_req  = $urandom_range(0, 1);
      cond_mask = 4'($urandom);
      cond_val  = 4'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
